mat_lpf_ctrl: RTL and testbench

- Frame sequencer for the 8-bit image RAM pair (source `Mats` instance, destination `Mats` instance).
- On `start`, scans the source image row-major at 1 pixel/clk and runs a 3-tap [1 2 1]/4 horizontal low-pass.
- Writes interior-pixel results to the same address in the destination RAM, then pulses `done`.
- Replaces the free-running tick/tapped-line logic in the test harness with a reusable, restartable controller.

---
 rtl/mat_lpf_ctrl_pkg.sv | 16 +
 rtl/mat_lpf_ctrl_lpf3_taps.sv | 63 ++++++
 rtl/mat_lpf_ctrl.sv | 154 +++++++++++++++
 tb/tb_mat_lpf_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_lpf_ctrl_pkg.sv
// rtl/mat_lpf_ctrl_pkg.sv - shared states and widths for the image low-pass frame sequencer
package mat_lpf_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int PIX_W     = 8;
    localparam int SUM_W     = 10;
    localparam int KSHIFT    = 2;
    localparam int FLUSH_CYC = 3;

endpackage

// File: rtl/mat_lpf_ctrl_lpf3_taps.sv
// rtl/mat_lpf_ctrl_lpf3_taps.sv - 3-stage tagged tap line with the [1 2 1]/4 kernel
module lpf3_taps
    import mat_lpf_ctrl_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int COL_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_v,
    input  logic [PIX_W-1:0]      i_d,
    input  logic [COL_W-1:0]      i_col,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_win_v,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [PIX_W-1:0]      o_q
);

    localparam logic [COL_W:0] C_ONE = (COL_W+1)'(1);
    localparam logic [COL_W:0] C_HI  = (COL_W+1)'(COLS - 2);

    logic [2:0]            r_v;
    logic [PIX_W-1:0]      r_d0, r_d1, r_d2;
    logic [COL_W-1:0]      r_col0, r_col1, r_col2;
    logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
    logic [COL_W:0]        w_c0, w_c1, w_c2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_d0    <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_col0  <= '0;
            r_col1  <= '0;
            r_col2  <= '0;
            r_addr0 <= '0;
            r_addr1 <= '0;
        end else if (i_en) begin
            r_v     <= {r_v[1:0], i_v};
            r_d0    <= i_d;
            r_d1    <= r_d0;
            r_d2    <= r_d1;
            r_col0  <= i_col;
            r_col1  <= r_col0;
            r_col2  <= r_col1;
            r_addr0 <= i_addr;
            r_addr1 <= r_addr0;
        end
    end

    // Consecutive columns around an interior centre can only come from one row.
    assign w_c0    = {1'b0, r_col0};
    assign w_c1    = {1'b0, r_col1};
    assign w_c2    = {1'b0, r_col2};
    assign o_win_v = (&r_v) && (w_c1 >= C_ONE) && (w_c1 <= C_HI)
                     && (w_c0 == w_c1 + C_ONE) && (w_c2 + C_ONE == w_c1);
    assign o_addr  = r_addr1;
    assign o_q     = PIX_W'((SUM_W'(r_d2) + (SUM_W'(r_d1) << 1) + SUM_W'(r_d0)) >> KSHIFT);

endmodule

// File: rtl/mat_lpf_ctrl.sv
// rtl/mat_lpf_ctrl.sv - frame sequencer: source scan, 3-tap low-pass, destination write; MAT_LPF_CTRL_STALL_EN adds stall
module mat_lpf_ctrl
    import mat_lpf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int COLS       = 16,
    parameter int ROWS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef MAT_LPF_CTRL_STALL_EN
    input  logic                  stall,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] src_addr,
    output logic                  src_oe,
    input  logic [PIX_W-1:0]      src_rd_q,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  dst_we,
    output logic [PIX_W-1:0]      dst_wr_q
);

    localparam int                    COL_W     = $clog2(COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROWS*COLS - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [COL_W-1:0]      r_col;
    logic [1:0]            r_flush;
    logic                  r_rd_v;
    logic [COL_W-1:0]      r_rd_col;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_skid_v;
    logic [PIX_W-1:0]      r_skid_d;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_dst_addr;
    logic [PIX_W-1:0]      r_dst_q;
    logic                  w_stall, w_adv, w_issue, w_win_v;
    logic [PIX_W-1:0]      w_rd_d, w_tap_q;
    logic [ADDR_WIDTH-1:0] w_tap_addr;

`ifdef MAT_LPF_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif
    assign w_adv   = !w_stall;
    assign w_issue = (r_state == S_READ) && w_adv;

    always_ff @(posedge clk) begin
        if (rst)        r_state <= S_IDLE;
        else if (w_adv) r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE) && w_adv;
        src_oe   = w_issue;
        dst_we   = r_we && w_adv;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  if (r_addr == LAST_ADDR) w_next = S_FLUSH;
            S_FLUSH: if (r_flush == 2'(FLUSH_CYC - 1)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_col   <= '0;
            r_flush <= '0;
        end else if (w_adv) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= '0;
                        r_col  <= '0;
                    end
                end
                S_READ: begin
                    if (r_addr != LAST_ADDR) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        r_col  <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
                    end
                end
                S_FLUSH: r_flush <= r_flush + 2'd1;
                default: r_flush <= '0;
            endcase
        end
    end

    // Data for a read returns while the line may be stalled; park it until the taps move.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v    <= 1'b0;
            r_rd_col  <= '0;
            r_rd_addr <= '0;
            r_skid_v  <= 1'b0;
            r_skid_d  <= '0;
        end else if (w_adv) begin
            r_rd_v    <= w_issue;
            r_rd_col  <= r_col;
            r_rd_addr <= r_addr;
            r_skid_v  <= 1'b0;
        end else if (r_rd_v && !r_skid_v) begin
            r_skid_v  <= 1'b1;
            r_skid_d  <= src_rd_q;
        end
    end

    assign w_rd_d = r_skid_v ? r_skid_d : src_rd_q;

    lpf3_taps #(
        .COLS       (COLS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_W      (COL_W)
    ) u_taps (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_v     (r_rd_v),
        .i_d     (w_rd_d),
        .i_col   (r_rd_col),
        .i_addr  (r_rd_addr),
        .o_win_v (w_win_v),
        .o_addr  (w_tap_addr),
        .o_q     (w_tap_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_dst_addr <= '0;
            r_dst_q    <= '0;
        end else if (w_adv) begin
            r_we <= w_win_v;
            if (w_win_v) begin
                r_dst_addr <= w_tap_addr;
                r_dst_q    <= w_tap_q;
            end
        end
    end

    assign src_addr = r_addr;
    assign dst_addr = r_dst_addr;
    assign dst_wr_q = r_dst_q;

endmodule

// File: tb/tb_mat_lpf_ctrl.sv
// tb/tb_mat_lpf_ctrl.sv - scoreboard bench for mat_lpf_ctrl with a 16x16 and a 4x2 instance
`timescale 1ns/1ps
module tb_mat_lpf_ctrl;

    localparam int AW = 8, C = 16, R = 16, N = C*R;
    localparam int SAW = 3, SC = 4, SR = 2, SN = SC*SR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, busy, done, src_oe, dst_we;
    logic [AW-1:0] src_addr, dst_addr;
    logic [7:0]    src_rd_q, dst_wr_q;
    logic           start_s, busy_s, done_s, src_oe_s, dst_we_s;
    logic [SAW-1:0] src_addr_s, dst_addr_s;
    logic [7:0]     src_rd_q_s, dst_wr_q_s;
`ifdef MAT_LPF_CTRL_STALL_EN
    logic stall = 1'b0;
    bit   stall_en = 1'b0;
`endif

    logic [7:0] smem [N];
    logic [7:0] dmem [N];
    logic [7:0] saved [N];
    logic [7:0] smem_s [SN];
    logic [7:0] dmem_s [SN];

    int checks = 0, errors = 0;
    int n_wr = 0, n_wr_s = 0, n_done_s = 0, cyc = 0, last_wr_cyc = 0;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];

    mat_lpf_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef MAT_LPF_CTRL_STALL_EN
        .stall    (stall),
`endif
        .busy     (busy),
        .done     (done),
        .src_addr (src_addr),
        .src_oe   (src_oe),
        .src_rd_q (src_rd_q),
        .dst_addr (dst_addr),
        .dst_we   (dst_we),
        .dst_wr_q (dst_wr_q)
    );

    mat_lpf_ctrl #(.ADDR_WIDTH(SAW), .COLS(SC), .ROWS(SR)) u_small (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
`ifdef MAT_LPF_CTRL_STALL_EN
        .stall    (1'b0),
`endif
        .busy     (busy_s),
        .done     (done_s),
        .src_addr (src_addr_s),
        .src_oe   (src_oe_s),
        .src_rd_q (src_rd_q_s),
        .dst_addr (dst_addr_s),
        .dst_we   (dst_we_s),
        .dst_wr_q (dst_wr_q_s)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_oe)   src_rd_q   <= smem[src_addr];
        if (src_oe_s) src_rd_q_s <= smem_s[src_addr_s];
    end

`ifdef MAT_LPF_CTRL_STALL_EN
    always @(posedge clk) begin
        #1;
        stall = stall_en && ($urandom_range(0, 99) < 30);
    end
`endif

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (dst_we) begin
            n_wr++;
            last_wr_cyc = cyc;
            dmem[dst_addr] = dst_wr_q;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: dst_addr=%0d data=%0d, no write expected", dst_addr, dst_wr_q);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(dst_addr), e.addr);
                check("wr_data", int'(dst_wr_q), e.data);
            end
        end
        if (!busy) check("idle_quiet", int'(src_oe | dst_we), 0);
`ifdef MAT_LPF_CTRL_STALL_EN
        if (stall) check("stall_quiet", int'(src_oe | dst_we), 0);
`endif
        if (dst_we_s) begin
            n_wr_s++;
            dmem_s[dst_addr_s] = dst_wr_q_s;
        end
        if (done_s) n_done_s++;
    end

    function automatic int ref_px(input int a);
        return (int'(smem[a-1]) + 2*int'(smem[a]) + int'(smem[a+1])) / 4;
    endfunction

    task automatic push_expected();
        wr_t w;
        for (int r = 0; r < R; r++)
            for (int c = 1; c < C-1; c++) begin
                w.addr = r*C + c;
                w.data = ref_px(r*C + c);
                exp_q.push_back(w);
            end
    endtask

    task automatic check_image(input string name);
        int bad, c, expv;
        bad = 0;
        for (int a = 0; a < N; a++) begin
            c = a % C;
            expv = (c == 0 || c == C-1) ? 32'h5A : ref_px(a);
            if (int'(dmem[a]) != expv) bad++;
        end
        check({name, "_image_bad_pixels"}, bad, 0);
    endtask

    task automatic pulse_start();
        int k;
        k = 0;
        start = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 100);
        start = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit chk_lat);
        int busy_cnt, n_done, wr0;
        for (int a = 0; a < N; a++) dmem[a] = 8'h5A;
        push_expected();
        wr0 = n_wr;
        pulse_start();
        busy_cnt = 0;
        n_done = 0;
        for (int k = 0; k < 5000; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (chk_lat) check({name, "_done_after_last_write"}, cyc - last_wr_cyc, 1);
                break;
            end
            start = (k == 40);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_seen"}, n_done, 1);
        @(negedge clk);
        check({name, "_idle_after_done"}, int'(busy), 0);
        if (chk_lat) check({name, "_busy_cycles"}, busy_cnt, N + 3 + 1);
        check({name, "_write_count"}, n_wr - wr0, R*(C-2));
        check({name, "_scoreboard_drained"}, exp_q.size(), 0);
        check_image(name);
    endtask

    task automatic run_small(output int nw, output int nd);
        int nw0, nd0;
        for (int a = 0; a < SN; a++) dmem_s[a] = 8'hEE;
        nw0 = n_wr_s;
        nd0 = n_done_s;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 0; k < 200 && !done_s; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        nw = n_wr_s - nw0;
        nd = n_done_s - nd0;
    endtask

    initial begin
        int nw, nd, k, wr0, bad;
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        for (int a = 0; a < N; a++) begin
            smem[a] = '0;
            dmem[a] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_src_oe", int'(src_oe), 0);
        check("rst_dst_we", int'(dst_we), 0);
        check("rst_src_addr", int'(src_addr), 0);
        check("rst_dst_addr", int'(dst_addr), 0);
        check("rst_dst_wr_q", int'(dst_wr_q), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < SN; a++) smem_s[a] = 8'(a);
        run_small(nw, nd);
        check("small_ramp_writes", nw, 4);
        check("small_ramp_done", nd, 1);
        check("small_ramp_d1", int'(dmem_s[1]), 1);
        check("small_ramp_d2", int'(dmem_s[2]), 2);
        check("small_ramp_d5", int'(dmem_s[5]), 5);
        check("small_ramp_d6", int'(dmem_s[6]), 6);
        check("small_ramp_edges", int'({dmem_s[0], dmem_s[3], dmem_s[4], dmem_s[7]}), int'(32'hEEEEEEEE));

        for (int a = 0; a < SN; a++) smem_s[a] = (a % 2 == 1) ? 8'hFF : 8'h00;
        run_small(nw, nd);
        check("small_alt_writes", nw, 4);
        check("small_alt_interior", int'({dmem_s[1], dmem_s[2], dmem_s[5], dmem_s[6]}), int'(32'h7F7F7F7F));
        check("small_alt_edges", int'({dmem_s[0], dmem_s[3], dmem_s[4], dmem_s[7]}), int'(32'hEEEEEEEE));

        for (int a = 0; a < N; a++) smem[a] = 8'(a);
        run_frame("ramp", 1'b1);
        run_frame("ramp_b2b", 1'b1);

        for (int a = 0; a < N; a++) smem[a] = 8'hFF;
        run_frame("ones", 1'b1);
        check("ones_pixel17", int'(dmem[17]), 255);

        for (int a = 0; a < N; a++) smem[a] = (a % 2 == 1) ? 8'hFF : 8'h00;
        run_frame("alt", 1'b1);

        for (int a = 0; a < N; a++) smem[a] = 8'($urandom);
        push_expected();
        pulse_start();
        k = 0;
        while (int'(src_addr) != 3*C + 5 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_row3", int'(k < 1000), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_src_oe", int'(src_oe), 0);
        check("midrst_dst_we", int'(dst_we), 0);
        check("midrst_src_addr", int'(src_addr), 0);
        check("midrst_dst_addr", int'(dst_addr), 0);
        check("midrst_dst_wr_q", int'(dst_wr_q), 0);
        rst = 1'b0;
        exp_q.delete();
        wr0 = n_wr;
        repeat (20) @(negedge clk);
        check("no_write_after_rst", n_wr - wr0, 0);
        run_frame("after_rst", 1'b1);

        for (int a = 0; a < N; a++) smem[a] = 8'($urandom);
        run_frame("rand", 1'b1);

`ifdef MAT_LPF_CTRL_STALL_EN
        for (int a = 0; a < N; a++) saved[a] = dmem[a];
        stall_en = 1'b1;
        run_frame("stall", 1'b0);
        stall_en = 1'b0;
        bad = 0;
        for (int a = 0; a < N; a++) if (dmem[a] != saved[a]) bad++;
        check("stall_matches_nostall", bad, 0);
`else
        for (int a = 0; a < N; a++) saved[a] = dmem[a];
        bad = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
